// File: rtl/rv32_lsu.sv
// RV32 load/store unit: one outstanding data-bus transaction at a time.
// Accepts a pipeline request, formats byte enables and write data, waits for
// grant and response, and returns the extended load result. Misaligned
// accesses and bus timeouts complete with an error flag instead.
//
// state | meaning
// IDLE  | ready for a request; misaligned requests complete from here
// REQ   | data_req_o high, waiting for data_gnt_i
// RESP  | granted, waiting for data_rvalid_i
module rv32_lsu #(
   parameter int unsigned MAX_WAIT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        ready_o,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_misalign_o,
   output logic        err_timeout_o,
   output logic        data_req_o,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   // The counter reaches MAX_WAIT_CYCLES on the edge after it holds this value.
   localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT_CYCLES - 1);

   state_t      state;
   state_t      state_nx;
   logic [15:0] wait_cnt;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [1:0]  off_q;

   logic        accept;
   logic        misaligned;
   logic        timeout_hit;
   logic [3:0]  be_fmt;
   logic [31:0] wdata_fmt;
   logic [31:0] shifted;
   logic [31:0] load_ext;

   assign ready_o     = (state == IDLE);
   assign accept      = req_i && ready_o;
   assign timeout_hit = (wait_cnt == WAIT_LAST);

   // Alignment check on the incoming request.
   always_comb begin
      misaligned = 1'b0;
      case (size_i)
         2'b01:   misaligned = addr_i[0];
         2'b10:   misaligned = |addr_i[1:0];
         2'b11:   misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   // Byte enables and replicated write data for the bus.
   always_comb begin
      be_fmt    = 4'b1111;
      wdata_fmt = wdata_i;
      case (size_i)
         2'b00: begin
            be_fmt    = 4'b0001 << addr_i[1:0];
            wdata_fmt = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_fmt    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{wdata_i[15:0]}};
         end
         default: begin
            be_fmt    = 4'b1111;
            wdata_fmt = wdata_i;
         end
      endcase
   end

   // Right-align the response and sign/zero extend to the captured size.
   always_comb begin
      shifted  = data_rdata_i >> {off_q, 3'b000};
      load_ext = shifted;
      case (size_q)
         2'b00:   load_ext = uns_q ? {24'd0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = uns_q ? {16'd0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   // Next-state logic; a response in RESP takes priority over the timeout.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept && !misaligned) state_nx = REQ;
         end
         REQ: begin
            if (timeout_hit)     state_nx = IDLE;
            else if (data_gnt_i) state_nx = RESP;
         end
         RESP: begin
            if (data_rvalid_i)    state_nx = IDLE;
            else if (timeout_hit) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nx;
   end

   // Request capture, bus outputs, wait counter and completion pulses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt       <= '0;
         size_q         <= '0;
         uns_q          <= 1'b0;
         off_q          <= '0;
         data_req_o     <= 1'b0;
         data_addr_o    <= '0;
         data_we_o      <= 1'b0;
         data_be_o      <= '0;
         data_wdata_o   <= '0;
         done_o         <= 1'b0;
         rdata_o        <= '0;
         err_misalign_o <= 1'b0;
         err_timeout_o  <= 1'b0;
      end else begin
         done_o         <= 1'b0;
         err_misalign_o <= 1'b0;
         err_timeout_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  wait_cnt <= '0;
                  size_q   <= size_i;
                  uns_q    <= unsigned_i;
                  off_q    <= addr_i[1:0];
                  if (misaligned) begin
                     done_o         <= 1'b1;
                     err_misalign_o <= 1'b1;
                     rdata_o        <= '0;
                  end else begin
                     data_req_o   <= 1'b1;
                     data_addr_o  <= {addr_i[31:2], 2'b00};
                     data_we_o    <= we_i;
                     data_be_o    <= be_fmt;
                     data_wdata_o <= wdata_fmt;
                  end
               end
            end
            REQ: begin
               wait_cnt <= 16'(wait_cnt + 16'd1);
               if (timeout_hit) begin
                  data_req_o    <= 1'b0;
                  done_o        <= 1'b1;
                  err_timeout_o <= 1'b1;
                  rdata_o       <= '0;
               end else if (data_gnt_i) begin
                  data_req_o <= 1'b0;
               end
            end
            RESP: begin
               wait_cnt <= 16'(wait_cnt + 16'd1);
               if (data_rvalid_i) begin
                  done_o  <= 1'b1;
                  rdata_o <= data_we_o ? 32'd0 : load_ext;
               end else if (timeout_hit) begin
                  done_o        <= 1'b1;
                  err_timeout_o <= 1'b1;
                  rdata_o       <= '0;
               end
            end
            default: begin
               data_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_lsu.sv
// Bench for rv32_lsu: directed scenarios plus randomized transactions checked
// against an arithmetic reference model of the access rules.
module tb_rv32_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i, req_i, we_i, unsigned_i, data_gnt_i, data_rvalid_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i, data_rdata_i;
   logic        ready_o, done_o, err_misalign_o, err_timeout_o;
   logic        data_req_o, data_we_o;
   logic [31:0] rdata_o, data_addr_o, data_wdata_o;
   logic [3:0]  data_be_o;

   int errors = 0;
   int checks = 0;

   // observations of the last transaction
   int          o_nreq, o_first_k, o_done_k;
   logic        o_stable, o_ready, o_we, o_mis, o_to;
   logic [31:0] o_addr, o_wdata, o_rdata;
   logic [3:0]  o_be;

   // request presented in the done cycle when chaining
   logic        nx_we, nx_uns;
   logic [1:0]  nx_size;
   logic [31:0] nx_addr, nx_wdata;

   rv32_lsu #(.MAX_WAIT_CYCLES(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .ready_o(ready_o),
      .we_i(we_i), .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o),
      .err_misalign_o(err_misalign_o), .err_timeout_o(err_timeout_o),
      .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
      .data_rdata_i(data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- reference model ----------------
   function automatic bit m_mis(input logic [1:0] s, input logic [31:0] a);
      return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
      int v;
      if (s == 2'd0)      v = 1 << (a % 4);
      else if (s == 2'd1) v = 3 << (a % 4);
      else                v = 15;
      return 4'(v);
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] s, input logic [31:0] w);
      if (s == 2'd0) return (w % 256) * 32'h0101_0101;
      if (s == 2'd1) return (w % 65536) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_ld(input logic [1:0] s, input logic u,
                                        input logic [31:0] a, input logic [31:0] bus);
      logic [31:0] v;
      v = bus / (32'd1 << (8 * (a % 4)));
      if (s == 2'd0) begin
         v = v % 256;
         if (!u && v >= 128) v = v - 256;
      end else if (s == 2'd1) begin
         v = v % 65536;
         if (!u && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   // ---------------- bus-side driver (observes, does not judge) ----------------
   task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] bus_rdata, input int gd, input int rd,
                          input bit noise, input bit presented, input bit chain);
      int gnt_k;
      gnt_k = 0;
      if (!presented) begin
         @(negedge clk_i);
         req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
         addr_i = addr; wdata_i = wdata;
      end
      o_ready = ready_o;
      data_rdata_i = bus_rdata;
      o_nreq = 0; o_first_k = -1; o_done_k = -1; o_stable = 1'b1;
      o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
      o_mis = 1'b0; o_to = 1'b0; o_rdata = 32'hDEAD_DEAD;
      @(posedge clk_i);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_i);
         req_i = 1'b0;
         if (done_o) begin
            o_done_k = k; o_mis = err_misalign_o; o_to = err_timeout_o; o_rdata = rdata_o;
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
            if (chain) begin
               req_i = 1'b1; we_i = nx_we; size_i = nx_size; unsigned_i = nx_uns;
               addr_i = nx_addr; wdata_i = nx_wdata;
            end
            break;
         end
         if (data_req_o) begin
            o_nreq++;
            if (o_nreq == 1) begin
               o_first_k = k; o_addr = data_addr_o; o_be = data_be_o;
               o_wdata = data_wdata_o; o_we = data_we_o;
            end else if (data_addr_o !== o_addr || data_be_o !== o_be ||
                         data_wdata_o !== o_wdata || data_we_o !== o_we) begin
               o_stable = 1'b0;
            end
            data_rvalid_i = noise;
            if (o_nreq - 1 == gd) begin
               data_gnt_i = 1'b1; gnt_k = k;
            end else begin
               data_gnt_i = 1'b0;
            end
         end else begin
            data_gnt_i = 1'b0;
            data_rvalid_i = (gnt_k > 0 && rd >= 0 && k == gnt_k + 1 + rd);
         end
      end
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = '0; unsigned_i = 1'b0;
      addr_i = '0; wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({done_o, err_misalign_o, err_timeout_o, data_req_o, data_we_o} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got=%b want=00000",
            {done_o, err_misalign_o, err_timeout_o, data_req_o, data_we_o});
      end
      checks++;
      if ({data_addr_o, data_wdata_o, rdata_o, data_be_o} !== 100'd0) begin
         errors++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h be=%b want all 0",
            data_addr_o, data_wdata_o, rdata_o, data_be_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
   endtask

   task automatic test_lb();
      run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_be !== 4'b1000) begin errors++; $display("FAIL lb_be got=%b want=1000", o_be); end
      checks++;
      if (o_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got=%h want=100", o_addr); end
      checks++;
      if (o_done_k != 3) begin errors++; $display("FAIL lb_latency got=%0d want=3", o_done_k); end
      checks++;
      if (o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got=%h want=ffffff80", o_rdata); end
      checks++;
      if ({o_mis, o_to, o_we} !== 3'b0) begin errors++; $display("FAIL lb_flags got=%b want=000", {o_mis, o_to, o_we}); end
      repeat (2) @(negedge clk_i);
      checks++;
      if (rdata_o !== 32'hFFFF_FF80 || done_o !== 1'b0) begin
         errors++; $display("FAIL lb_hold rdata=%h done=%b want ffffff80/0", rdata_o, done_o);
      end
   endtask

   task automatic test_sh();
      run_txn(1'b1, 2'd1, 1'b0, 32'h206, 32'h0000_ABCD, 32'h1234_5678, 4, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_nreq != 5 || o_stable !== 1'b1) begin
         errors++; $display("FAIL sh_hold req_cycles=%0d stable=%b want 5/1", o_nreq, o_stable);
      end
      checks++;
      if (o_be !== 4'b1100 || o_addr !== 32'h204 || o_we !== 1'b1) begin
         errors++; $display("FAIL sh_bus be=%b addr=%h we=%b want 1100/204/1", o_be, o_addr, o_we);
      end
      checks++;
      if (o_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got=%h want=abcdabcd", o_wdata); end
      checks++;
      if (o_done_k != 7 || o_rdata !== 32'h0) begin
         errors++; $display("FAIL sh_done k=%0d rdata=%h want 7/0", o_done_k, o_rdata);
      end
   endtask

   task automatic test_misalign();
      run_txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_nreq != 0 || o_done_k != 1 || o_mis !== 1'b1 || o_to !== 1'b0) begin
         errors++; $display("FAIL mis_lw req=%0d k=%0d mis=%b to=%b want 0/1/1/0", o_nreq, o_done_k, o_mis, o_to);
      end
      run_txn(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_nreq != 0 || o_done_k != 1 || o_mis !== 1'b1 || o_to !== 1'b0) begin
         errors++; $display("FAIL mis_size3 req=%0d k=%0d mis=%b to=%b want 0/1/1/0", o_nreq, o_done_k, o_mis, o_to);
      end
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, -1, -1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_nreq != 8 || o_done_k != 9 || o_to !== 1'b1 || o_mis !== 1'b0) begin
         errors++; $display("FAIL to_nogrant req=%0d k=%0d to=%b mis=%b want 8/9/1/0", o_nreq, o_done_k, o_to, o_mis);
      end
      data_rdata_i = 32'h5555_5555;
      data_rvalid_i = 1'b1;
      @(negedge clk_i);
      data_rvalid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL to_late_rvalid cyc=%0d done=%b ready=%b want 0/1", i, done_o, ready_o);
         end
         @(negedge clk_i);
      end
      run_txn(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'h0, 1, -1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_done_k != 9 || o_to !== 1'b1) begin
         errors++; $display("FAIL to_in_resp k=%0d to=%b want 9/1", o_done_k, o_to);
      end
      run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 3, 3, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_done_k != 9 || o_to !== 1'b0 || o_rdata !== 32'h1234_5678) begin
         errors++; $display("FAIL to_rvalid_wins k=%0d to=%b rdata=%h want 9/0/12345678", o_done_k, o_to, o_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int seen_done;
      seen_done = 0;
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; unsigned_i = 1'b0; addr_i = 32'h104;
      @(negedge clk_i);
      req_i = 1'b0;
      data_gnt_i = data_req_o;
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({done_o, data_req_o, data_we_o, err_misalign_o, err_timeout_o} !== 5'b0 ||
          {data_addr_o, data_wdata_o, rdata_o, data_be_o} !== 100'd0) begin
         errors++; $display("FAIL rstmid_outputs done=%b req=%b addr=%h be=%b rdata=%h want all 0",
            done_o, data_req_o, data_addr_o, data_be_o, rdata_o);
      end
      rst_i = 1'b0;
      data_rdata_i = 32'hAAAA_AAAA;
      data_rvalid_i = 1'b1;
      @(negedge clk_i);
      data_rvalid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done_o) seen_done++;
         @(negedge clk_i);
      end
      checks++;
      if (seen_done != 0 || ready_o !== 1'b1) begin
         errors++; $display("FAIL rstmid_ignored done_count=%0d ready=%b want 0/1", seen_done, ready_o);
      end
      run_txn(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'hF00D_0000, 0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_rdata !== 32'h0000_F00D || o_done_k != 3) begin
         errors++; $display("FAIL rstmid_lhu rdata=%h k=%0d want 0000f00d/3", o_rdata, o_done_k);
      end
   endtask

   task automatic test_back_to_back();
      nx_we = 1'b0; nx_size = 2'd0; nx_uns = 1'b1; nx_addr = 32'h41; nx_wdata = 32'h0;
      run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hCAFE_BABE, 0, 0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (o_done_k != 3 || o_rdata !== 32'hCAFE_BABE) begin
         errors++; $display("FAIL b2b_first k=%0d rdata=%h want 3/cafebabe", o_done_k, o_rdata);
      end
      run_txn(nx_we, nx_size, nx_uns, nx_addr, nx_wdata, 32'h0000_9900, 0, 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (o_ready !== 1'b1 || o_first_k != 1) begin
         errors++; $display("FAIL b2b_accept ready=%b first_req_cycle=%0d want 1/1", o_ready, o_first_k);
      end
      checks++;
      if (o_rdata !== 32'h0000_0099 || o_be !== 4'b0010) begin
         errors++; $display("FAIL b2b_second rdata=%h be=%b want 00000099/0010", o_rdata, o_be);
      end
   endtask

   task automatic test_random();
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] addr, wdata, bus;
      int          gd, rd;
      bit          noise;
      for (int n = 0; n < 40; n++) begin
         we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom; bus = $urandom;
         if ($urandom_range(0, 2) != 0) addr = addr & ~((size == 2'd2) ? 32'd3 : (size == 2'd1) ? 32'd1 : 32'd0);
         gd = $urandom_range(0, 2); rd = $urandom_range(0, 2); noise = 1'($urandom_range(0, 1));
         run_txn(we, size, uns, addr, wdata, bus, gd, rd, noise, 1'b0, 1'b0);
         if (m_mis(size, addr)) begin
            checks++;
            if (o_nreq != 0 || o_done_k != 1 || o_mis !== 1'b1 || o_to !== 1'b0) begin
               errors++; $display("FAIL rnd_mis n=%0d size=%0d addr=%h req=%0d k=%0d mis=%b want 0/1/1",
                  n, size, addr, o_nreq, o_done_k, o_mis);
            end
         end else begin
            checks++;
            if (o_addr !== {addr[31:2], 2'b00} || o_be !== m_be(size, addr) ||
                o_wdata !== m_wd(size, wdata) || o_we !== we || o_stable !== 1'b1) begin
               errors++; $display("FAIL rnd_bus n=%0d addr=%h be=%b wdata=%h we=%b want %h/%b/%h/%b",
                  n, o_addr, o_be, o_wdata, o_we, {addr[31:2], 2'b00}, m_be(size, addr), m_wd(size, wdata), we);
            end
            checks++;
            if (o_nreq != gd + 1 || o_done_k != gd + rd + 3 || o_mis !== 1'b0 || o_to !== 1'b0) begin
               errors++; $display("FAIL rnd_timing n=%0d req=%0d k=%0d mis=%b to=%b want %0d/%0d/0/0",
                  n, o_nreq, o_done_k, o_mis, o_to, gd + 1, gd + rd + 3);
            end
            checks++;
            if (o_rdata !== (we ? 32'd0 : m_ld(size, uns, addr, bus))) begin
               errors++; $display("FAIL rnd_rdata n=%0d size=%0d uns=%b addr=%h bus=%h got=%h want=%h",
                  n, size, uns, addr, bus, o_rdata, we ? 32'd0 : m_ld(size, uns, addr, bus));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_misalign();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rv32_lsu.md
RV32_LSU -- requirements
Module: rv32_lsu

Interface
REQ-001 The block SHALL have parameter MAX_WAIT_CYCLES, default 255, meaning the cycles allowed in REQ+RESP before a bus timeout is declared (range 2..65535).
REQ-002 The block SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req_i  input  1  pipeline load/store request.
REQ-005 The block SHALL have port ready_o  output  1  request accepted this cycle if req_i is high.
REQ-006 The block SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have port unsigned_i  input  1  zero-extend load data (LBU/LHU).
REQ-009 The block SHALL have port addr_i  input  32  byte address.
REQ-010 The block SHALL have port wdata_i  input  32  store data, right-aligned.
REQ-011 The block SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port rdata_o  output  32  extended load result, valid while done_o is high.
REQ-013 The block SHALL have port err_misalign_o  output  1  misaligned/illegal-size flag, qualified by done_o.
REQ-014 The block SHALL have port err_timeout_o  output  1  bus-timeout flag, qualified by done_o.
REQ-015 The block SHALL have ports data_req_o out 1, data_addr_o out 32, data_we_o out 1, data_be_o out 4, data_wdata_o out 32: the bus request signals.
REQ-016 The block SHALL have ports data_gnt_i in 1, data_rvalid_i in 1, data_rdata_i in 32: the bus responses.

Function
REQ-017 The block SHALL implement states IDLE, REQ and RESP; ready_o = (state == IDLE).
REQ-018 Acceptance SHALL occur on an edge where req_i && ready_o; at that edge the address, size, we, unsigned and wdata SHALL be captured.
REQ-019 Misalignment SHALL be defined as: half with addr[0]=1; word with addr[1:0]!=0; size 11 always. On a misaligned acceptance the block SHALL stay in IDLE, issue no bus request, and pulse done_o with err_misalign_o in the next cycle.
REQ-020 On an aligned acceptance the block SHALL go to REQ; data_req_o SHALL be registered and high from the next cycle.
REQ-021 data_addr_o SHALL be {addr[31:2],2'b00}.
REQ-022 data_be_o SHALL be 0001<<addr[1:0] for a byte, 0011<<(2*addr[1]) for a half, and 1111 for a word.
REQ-023 data_wdata_o SHALL be {4{wdata[7:0]}} for a byte, {2{wdata[15:0]}} for a half, and wdata for a word.
REQ-024 data_req_o, addr, we, be and wdata SHALL be held stable in REQ until data_gnt_i is sampled high. data_gnt_i may be high in the first req cycle.
REQ-025 When grant is sampled, the block SHALL move REQ->RESP and drop data_req_o in the next cycle. Only one transaction SHALL be outstanding.
REQ-026 data_rvalid_i SHALL be honoured only in RESP (so no earlier than one cycle after grant); it applies to loads and stores alike.
REQ-027 When rvalid is sampled in RESP, the block SHALL return to IDLE and pulse done_o next cycle.
REQ-028 For a load, rdata_o SHALL be (data_rdata_i >> 8*addr[1:0]) truncated to the size, then sign- or zero-extended per unsigned_i. For a store, rdata_o SHALL be 0.
REQ-029 rdata_o SHALL hold until the next done_o.
REQ-030 Minimum load latency SHALL be 3 cycles from the acceptance edge to done_o (gnt immediate, rvalid next cycle).
REQ-031 The wait counter SHALL clear on acceptance and increment every cycle in REQ or RESP.
REQ-032 When the counter reaches MAX_WAIT_CYCLES with no completion, the block SHALL drop data_req_o, go to IDLE, and pulse done_o with err_timeout_o. A late rvalid in IDLE SHALL be ignored.
REQ-033 If rvalid and timeout coincide, rvalid SHALL win (normal completion).
REQ-034 A new request SHALL be acceptable in the cycle done_o is high.

Reset
REQ-035 While rst_i is sampled high: state = IDLE, counter = 0, and data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, done_o, rdata_o, err_misalign_o and err_timeout_o all 0; ready_o is 1 from the first cycle after reset.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no done_o; responses arriving after reset SHALL be ignored.

Verification
REQ-037 LB: addr 0x103, signed, rdata 0x80FF_1234, gnt immediate, rvalid +1 -> be 1000, addr 0x100, done at acceptance+3, rdata_o 0xFFFF_FF80.
REQ-038 SH: addr 0x206, wdata 0x0000_ABCD, gnt delayed 4 cycles -> req/addr/be 1100/wdata 0xABCD_ABCD stable for 5 cycles, done after rvalid, rdata_o 0.
REQ-039 LW at 0x102 -> no data_req_o, done_o + err_misalign_o one cycle later; size 11 at 0x0 gives the same.
REQ-040 MAX_WAIT_CYCLES=8, no gnt -> data_req_o drops after 8 cycles, done_o + err_timeout_o; a later rvalid is ignored.
REQ-041 rst_i asserted during RESP -> no done_o, outputs 0, the next LHU at 0x2 with rdata 0xF00D_0000 returns 0x0000_F00D.
REQ-042 Back-to-back: new req_i held high during the done_o cycle -> accepted on that edge, data_req_o high the next cycle.
